pix_interp_arb: RTL
===================

# pix_interp_arb

Round-robin arbiter that shares one vertex colour/texture interpolator among NREQ rasterizer lanes. It accepts 299-bit barycentric pixel packets from each lane, issues them one at a time to the interpolator, and records the issuing lane in an in-order tag FIFO. Each 57-bit interpolated pixel result is routed back to the lane that issued the packet. It sits between the rasterizer lanes and the interpolator's input/output handshakes.

## Interface
- NREQ, 2: number of requesting lanes, legal range 2..4.
- PKT_W, 299: packet width, {x[8:0], y[7:0], vertex colour/texture fields, u[20:0], v[20:0]}.
- PIX_W, 57: result width, {x, y, r, g, b, Tx, Ty}.
- TAG_DEPTH, 8: maximum number of in-flight packets; power of 2, minimum 2.
- clk_i  in  1  single clock, rising edge.
- reset_i  in  1  asynchronous, active-low reset.
- req_valid_i  in  NREQ  per-lane packet valid.
- req_ready_o  out  NREQ  per-lane accept; at most one bit is high per cycle.
- req_data_i  in  NREQ*PKT_W  lane k occupies [k*PKT_W +: PKT_W].
- out_valid_o  out  1  packet valid to the interpolator.
- out_ready_i  in  1  interpolator ready.
- out_data_o  out  PKT_W  registered packet.
- ret_valid_i  in  1  interpolated result valid.
- ret_ready_o  out  1  result accepted.
- ret_data_i  in  PIX_W  result from the interpolator.
- pix_valid_o  out  NREQ  per-lane result valid.
- pix_ready_i  in  NREQ  per-lane result ready.
- pix_data_o  out  PIX_W  shared result bus, equal to ret_data_i.
- inflight_o  out  $clog2(TAG_DEPTH)+1  packets issued and not yet returned.
- err_o  out  1  sticky flag: a result arrived while no packet was in flight.

## Operation
- Reset value of every output is 0: req_ready_o, out_valid_o, out_data_o, ret_ready_o, pix_valid_o, inflight_o, err_o. The round-robin pointer resets to lane 0 and the tag FIFO resets to empty.
- **Issue slot free:** true when out_valid_o=0, or when out_valid_o=1 and out_ready_i=1.
- **Can issue:** true when the issue slot is free and inflight_o < TAG_DEPTH.
- **Grant:** when can issue is true, the grant goes to the first lane with req_valid_i=1, searching from the pointer upward and wrapping modulo NREQ. req_ready_o has a one-hot bit for the granted lane and is 0 otherwise. This output is combinational from req_valid_i, the pointer and the occupancy state.
- **Transfer:** a transfer happens when req_valid_i[k] and req_ready_o[k] are both high. On a transfer:
  - out_data_o is loaded with lane k's packet and out_valid_o is set to 1;
  - k is pushed into the tag FIFO;
  - the pointer is set to (k+1) mod NREQ.
- out_valid_o clears when out_ready_i=1 and there is no new transfer in that cycle. out_data_o holds its value while out_valid_o=1 and out_ready_i=0.
- **Return path (combinational):**
  - head = tag FIFO head;
  - pix_valid_o[k] = ret_valid_i & !tag_empty & (head==k);
  - ret_ready_o = !tag_empty & pix_ready_i[head].
- The tag FIFO pops when ret_valid_i and ret_ready_o are both high.
- If ret_valid_i=1 while the tag FIFO is empty: ret_ready_o stays 0, no pix_valid_o is asserted, and err_o sets and holds until reset.
- **In-flight count:** inflight_o = tag FIFO count. It increments on a transfer and decrements on a pop. A transfer and a pop in the same cycle leave it unchanged.
- **Full FIFO:** at inflight_o = TAG_DEPTH, no grant is issued, even if a pop occurs in the same cycle. Grants resume the cycle after the count drops.
- **Reset mid-operation:** the in-flight tags, the held packet and err_o are discarded immediately. Lanes must drop their own state on the same reset.

## Timing
- Transfer on edge N gives out_valid_o=1 from edge N onward. Issue latency is one cycle.
- Back-to-back issue is supported: one packet per cycle while out_ready_i=1 and the tag FIFO is below full.
- Return routing adds zero latency: ret_valid_i in cycle N produces pix_valid_o in cycle N.
- The arbitration is fair: with all lanes continuously valid, grants rotate 0,1,...,NREQ-1,0 with no lane skipped.
- A lane that drops req_valid_i before it is granted loses nothing. Packets are never reordered within a lane, and results are returned in issue order across lanes.

## Structure
- Shared package pix_interp_pkg:
  - PKT_W and PIX_W;
  - field offsets for x, y and u/v within the packet (x 298:290, y 289:282, u 41:21, v 20:0);
  - the result field layout.
- One sub-module, pix_tag_fifo: a synchronous FIFO of $clog2(NREQ) bits by TAG_DEPTH entries, with count, empty and full outputs and the same asynchronous active-low reset.
- The arbiter pointer, grant logic, output register and err flag live in the top module.

## Test plan
- **Single lane:** NREQ=2, lane 0 sends 3 packets with x=1,2,3 while out_ready_i=1 → out_data_o x sequence is 1,2,3, one per cycle. Looping the results back returns them on lane 0 only, and inflight_o returns to 0.
- **Round robin:** both lanes continuously valid → grants alternate 0,1,0,1. After 4 transfers the result order is lane 0, lane 1, lane 0, lane 1.
- **Tag full:** TAG_DEPTH=8, no returns → exactly 8 transfers occur, then req_ready_o=0 with inflight_o=8. One return → exactly 1 new grant on the following cycle.
- **Backpressure:**
  - out_ready_i=0 for 5 cycles → out_data_o is stable and no further grants are issued;
  - pix_ready_i[head]=0 → ret_ready_o=0 and the tag FIFO is unchanged.
- **Spurious return:** ret_valid_i=1 after reset with nothing in flight → err_o=1 the next cycle, pix_valid_o=0, and err_o persists.
- **Reset mid-operation:** assert reset_i low with 3 packets in flight → all outputs are 0 immediately. After release, a new transfer is granted to lane 0.

Source files
------------

// File: rtl/pix_interp_pkg.sv
// Shared widths and field layout for the pixel interpolator packets and results.
package pix_interp_pkg;

    localparam int PKT_W = 299;
    localparam int PIX_W = 57;

    localparam int X_HI = 298;
    localparam int X_LO = 290;
    localparam int Y_HI = 289;
    localparam int Y_LO = 282;
    localparam int U_HI = 41;
    localparam int U_LO = 21;
    localparam int V_HI = 20;
    localparam int V_LO = 0;

    typedef struct packed {
        logic [8:0] x;
        logic [7:0] y;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic [7:0] tx;
        logic [7:0] ty;
    } pix_res_t;

endpackage

// File: rtl/pix_tag_fifo.sv
// In-order FIFO of issuing-lane tags; head is the lane owed the next result.
module pix_tag_fifo #(
    parameter int W     = 1,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [W-1:0]               din,
    input  logic                       pop,
    output logic [W-1:0]               dout,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [DEPTH-1:0][W-1:0] mem;
    logic [AW-1:0]           wptr;
    logic [AW-1:0]           rptr;

    assign dout  = mem[rptr];
    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem   <= '0;
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[wptr] <= din;
                wptr      <= wptr + AW'(1);
            end
            if (pop)
                rptr <= rptr + AW'(1);
            if (push && !pop)
                count <= count + CNT_W'(1);
            else if (pop && !push)
                count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/pix_interp_arb.sv
// Round-robin arbiter sharing one interpolator among NREQ lanes, with
// in-order tag tracking to route results back to the issuing lane.
module pix_interp_arb #(
    parameter int NREQ      = 2,
    parameter int PKT_W     = pix_interp_pkg::PKT_W,
    parameter int PIX_W     = pix_interp_pkg::PIX_W,
    parameter int TAG_DEPTH = 8
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic [NREQ-1:0]             req_valid_i,
    output logic [NREQ-1:0]             req_ready_o,
    input  logic [NREQ*PKT_W-1:0]       req_data_i,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic [PKT_W-1:0]            out_data_o,
    input  logic                        ret_valid_i,
    output logic                        ret_ready_o,
    input  logic [PIX_W-1:0]            ret_data_i,
    output logic [NREQ-1:0]             pix_valid_o,
    input  logic [NREQ-1:0]             pix_ready_i,
    output logic [PIX_W-1:0]            pix_data_o,
    output logic [$clog2(TAG_DEPTH):0]  inflight_o,
    output logic                        err_o
);
    localparam int TAG_W = $clog2(NREQ);

    logic [TAG_W-1:0] ptr;
    logic [TAG_W-1:0] gnt_idx;
    logic [NREQ-1:0]  gnt;
    logic [TAG_W-1:0] head;
    logic             tag_empty;
    logic             tag_full;
    logic             can_issue;
    logic             xfer;
    logic             pop;

    // Gating on reset keeps req_ready_o low while lanes may still hold valid.
    assign can_issue = reset_i && (!out_valid_o || out_ready_i) && !tag_full;

    always_comb begin
        int  j;
        logic found;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        j       = 0;
        for (int i = 0; i < NREQ; i++) begin
            j = int'(ptr) + i;
            if (j >= NREQ)
                j = j - NREQ;
            if (!found && req_valid_i[j]) begin
                found   = 1'b1;
                gnt[j]  = 1'b1;
                gnt_idx = TAG_W'(j);
            end
        end
        if (!can_issue)
            gnt = '0;
    end

    assign req_ready_o = gnt;
    assign xfer        = |gnt;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            ptr         <= '0;
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            err_o       <= 1'b0;
        end else begin
            if (xfer) begin
                out_data_o  <= req_data_i[gnt_idx*PKT_W +: PKT_W];
                out_valid_o <= 1'b1;
                ptr         <= (gnt_idx == TAG_W'(NREQ-1)) ? '0 : gnt_idx + TAG_W'(1);
            end else if (out_ready_i) begin
                out_valid_o <= 1'b0;
            end
            if (ret_valid_i && tag_empty)
                err_o <= 1'b1;
        end
    end

    always_comb begin
        pix_valid_o = '0;
        for (int k = 0; k < NREQ; k++)
            pix_valid_o[k] = ret_valid_i && !tag_empty && (head == TAG_W'(k));
    end

    assign ret_ready_o = !tag_empty && pix_ready_i[head];
    assign pop         = ret_valid_i && ret_ready_o;
    assign pix_data_o  = ret_data_i;

    pix_tag_fifo #(
        .W     (TAG_W),
        .DEPTH (TAG_DEPTH)
    ) u_tags (
        .clk   (clk_i),
        .rst_n (reset_i),
        .push  (xfer),
        .din   (gnt_idx),
        .pop   (pop),
        .dout  (head),
        .count (inflight_o),
        .empty (tag_empty),
        .full  (tag_full)
    );

endmodule
